assoc_cache_controller: RTL

Two-way set-associative, write-through, no-write-allocate cache controller between the MEM stage and the SRAM controller. It is the parametrised successor of the direct-mapped controller, adding configurable set count and line width, LRU replacement, in-place update on write hit, a multi-cycle flush, and hit/miss counters. Tag, valid, LRU and data storage are internal.

---
 rtl/assoc_cache_controller_pkg.sv | 28 ++
 rtl/assoc_cache_controller_if.sv | 26 ++
 rtl/assoc_cache_controller_array.sv | 92 +++++++++
 rtl/assoc_cache_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/assoc_cache_controller_pkg.sv
// Shared types and address-split helpers for the two-way cache controller.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Word-offset bits inside a line.
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Set-index bits.
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits: everything above byte, word-offset and index fields.
    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - 2 - $clog2(sets) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/assoc_cache_controller_if.sv
// MEM-stage request bus of the cache: address, store data, load data and handshake.
// Latency: wires only.
// Backpressure: requester holds mem_r_en/mem_w_en and operands until ready.
interface assoc_cache_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] read_data;
    logic              ready;

    // MEM stage side: issues requests.
    modport master (
        output addr, write_data, mem_r_en, mem_w_en,
        input  read_data, ready
    );

    // Cache side: serves requests.
    modport slave (
        input  addr, write_data, mem_r_en, mem_w_en,
        output read_data, ready
    );
endinterface

// File: rtl/assoc_cache_controller_array.sv
// Two-way tag/valid/data store with one LRU bit per set.
// Latency: lookup is combinational; line/word/LRU writes and set-clear land on the next edge.
// Backpressure: none, every write port is accepted in the cycle it is asserted.
module assoc_cache_array
    import cache_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2,
    parameter int TAG_W      = 23,
    parameter int IDX_W      = $clog2(SETS),
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // lookup / write address (shared by all ports except set-clear)
    input  logic [IDX_W-1:0]             idx,
    input  logic [TAG_W-1:0]             tag,
    input  logic [OFF_W-1:0]             off,
    output logic                         hit,
    output logic                         hit_way,
    output logic [DATA_W-1:0]            hit_word,
    output logic                         valid_0,
    output logic                         valid_1,
    output logic                         lru,
    // whole-line fill
    input  logic                         line_we,
    input  logic                         line_way,
    input  logic [DATA_W*LINE_WORDS-1:0] line_dat,
    // single-word update on store hit
    input  logic                         word_we,
    input  logic                         word_way,
    input  logic [DATA_W-1:0]            word_dat,
    // LRU bit names the way to evict next
    input  logic                         lru_we,
    input  logic                         lru_val,
    // flush: clear valid and LRU of one set
    input  logic                         clr_en,
    input  logic [IDX_W-1:0]             clr_idx
);
    localparam int LINE_W = DATA_W * LINE_WORDS;

    logic [LINE_W-1:0] data_mem [2][SETS];
    logic [TAG_W-1:0]  tag_mem  [2][SETS];
    logic [SETS-1:0]   valid0_q;
    logic [SETS-1:0]   valid1_q;
    logic [SETS-1:0]   lru_q;

    logic              way0_hit;
    logic              way1_hit;
    logic [LINE_W-1:0] hit_line;

    assign valid_0  = valid0_q[idx];
    assign valid_1  = valid1_q[idx];
    assign lru      = lru_q[idx];
    assign way0_hit = valid0_q[idx] && (tag_mem[0][idx] == tag);
    assign way1_hit = valid1_q[idx] && (tag_mem[1][idx] == tag);
    assign hit      = way0_hit || way1_hit;
    assign hit_way  = way1_hit;
    assign hit_line = data_mem[hit_way][idx];
    assign hit_word = hit_line[off*DATA_W +: DATA_W];

    // Control bits: reset and flush make every set read invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            if (clr_en) begin
                valid0_q[clr_idx] <= 1'b0;
                valid1_q[clr_idx] <= 1'b0;
                lru_q[clr_idx]    <= 1'b0;
            end
            if (line_we) begin
                if (line_way) valid1_q[idx] <= 1'b1;
                else          valid0_q[idx] <= 1'b1;
            end
            if (lru_we) lru_q[idx] <= lru_val;
        end
    end

    // Payload storage is not reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[line_way][idx] <= line_dat;
            tag_mem[line_way][idx]  <= tag;
        end
        if (word_we) data_mem[word_way][idx][off*DATA_W +: DATA_W] <= word_dat;
    end

endmodule

// File: rtl/assoc_cache_controller.sv
// Two-way set-associative write-through, no-write-allocate cache between MEM stage and SRAM.
// Latency: load hit 0 cycles; miss/store complete in the cycle sram_ready is seen; flush takes SETS cycles.
// Backpressure: ready low while a miss, store or flush is outstanding; requester holds its request.
module assoc_cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    assoc_cache_controller_if.slave      mem,
    input  logic                         flush,
    output logic                         flush_busy,
    output logic [ADDR_W-1:0]            sram_addr,
    output logic [DATA_W-1:0]            sram_write_data,
    output logic                         sram_write_en,
    output logic                         sram_read_en,
    input  logic [DATA_W*LINE_WORDS-1:0] sram_read_data,
    input  logic                         sram_ready,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
);
    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  flush_cnt;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    logic              hit;
    logic              hit_way;
    logic [DATA_W-1:0] hit_word;
    logic              valid_0;
    logic              valid_1;
    logic              lru;
    logic              victim;

    logic              line_we;
    logic              word_we;
    logic              lru_we;
    logic              lru_val;
    logic              clr_en;
    logic              hit_inc;
    logic              miss_inc;

    assign off = mem.addr[2 +: OFF_W];
    assign idx = mem.addr[2+OFF_W +: IDX_W];
    assign tag = mem.addr[ADDR_W-1 -: TAG_W];

    // Fill an empty way first; only evict the LRU way when both are live.
    assign victim = !valid_0 ? 1'b0 : (!valid_1 ? 1'b1 : lru);

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;

    assoc_cache_array #(
        .DATA_W     (DATA_W),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx      (idx),
        .tag      (tag),
        .off      (off),
        .hit      (hit),
        .hit_way  (hit_way),
        .hit_word (hit_word),
        .valid_0  (valid_0),
        .valid_1  (valid_1),
        .lru      (lru),
        .line_we  (line_we),
        .line_way (victim),
        .line_dat (sram_read_data),
        .word_we  (word_we),
        .word_way (hit_way),
        .word_dat (mem.write_data),
        .lru_we   (lru_we),
        .lru_val  (lru_val),
        .clr_en   (clr_en),
        .clr_idx  (flush_cnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next state: stores win over loads, loads win over flush.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (mem.mem_w_en)                next_state = WRITE;
                else if (mem.mem_r_en && !hit)   next_state = FILL;
                else if (!mem.mem_r_en && flush) next_state = FLUSH;
                else                             next_state = IDLE;
            end
            FILL:    if (sram_ready) next_state = IDLE;
            WRITE:   if (sram_ready) next_state = IDLE;
            FLUSH:   if (flush_cnt == IDX_W'(SETS - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs and array strobes; everything idles at zero outside its state.
    always_comb begin
        mem.read_data   = '0;
        mem.ready       = (state != FLUSH) && (next_state == IDLE);
        sram_addr       = '0;
        sram_write_data = '0;
        sram_write_en   = 1'b0;
        sram_read_en    = 1'b0;
        flush_busy      = 1'b0;
        line_we         = 1'b0;
        word_we         = 1'b0;
        lru_we          = 1'b0;
        lru_val         = 1'b0;
        clr_en          = 1'b0;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!mem.mem_w_en && mem.mem_r_en && hit) begin
                    mem.read_data = hit_word;
                    lru_we        = 1'b1;
                    lru_val       = ~hit_way;
                    hit_inc       = 1'b1;
                end
            end
            FILL: begin
                sram_read_en = 1'b1;
                sram_addr    = {mem.addr[ADDR_W-1:2+OFF_W], {(2+OFF_W){1'b0}}};
                if (sram_ready) begin
                    line_we       = 1'b1;
                    lru_we        = 1'b1;
                    lru_val       = ~victim;
                    mem.read_data = sram_read_data[off*DATA_W +: DATA_W];
                    miss_inc      = 1'b1;
                end
            end
            WRITE: begin
                sram_write_en   = 1'b1;
                sram_addr       = mem.addr;
                sram_write_data = mem.write_data;
                if (sram_ready && hit) begin
                    word_we = 1'b1;
                    lru_we  = 1'b1;
                    lru_val = ~hit_way;
                end
            end
            FLUSH: begin
                flush_busy = 1'b1;
                clr_en     = 1'b1;
            end
            default: ;
        endcase
    end

    // Flush walks sets 0..SETS-1 and wraps back to 0 on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              flush_cnt <= '0;
        else if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
        else                     flush_cnt <= '0;
    end

    // Load hit/miss counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 1'b1;
            if (miss_inc && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
        end
    end

endmodule
